// File: rtl/min_width_pulse_gen_if.sv
// Trigger/status bundle between control logic and min_width_pulse_gen.
// The master side drives requests; the slave side (the generator) drives the shaped pulse and status.
interface min_width_pulse_gen_if #(
    parameter int CNT_W = 3
);
    logic             enable;
    logic             trigger;
    logic             clr_overflow;
    logic             pulse_out;
    logic             busy;
    logic [CNT_W-1:0] pending;
    logic             overflow;

    modport master (
        output enable, trigger, clr_overflow,
        input  pulse_out, busy, pending, overflow
    );

    modport slave (
        input  enable, trigger, clr_overflow,
        output pulse_out, busy, pending, overflow
    );
endinterface

// File: rtl/min_width_pulse_gen.sv
// Turns single-cycle triggers into pulses of fixed high width and minimum low gap.
// Define PULSE_GEN_QUEUE_EN to queue triggers that arrive while a pulse is in flight.
module min_width_pulse_gen #(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 4,
    parameter int MAX_PENDING = 7,
    parameter int CNT_W       = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    min_width_pulse_gen_if.slave bus
);
    localparam int PH_MAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0] HIGH_LOAD = PH_W'(HIGH_CYCLES - 1);
    localparam logic [PH_W-1:0] LOW_LOAD  = PH_W'(LOW_CYCLES - 1);

`ifdef PULSE_GEN_QUEUE_EN
    localparam bit QUEUE_EN = 1'b1;
`else
    localparam bit QUEUE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic            pulse_q;
    logic            overflow_q;
    logic            start;
    logic            drop;
    logic            have_work;

    // Phase counter counts down to zero and is reloaded on every state entry.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d = state_q;
        phase_d = phase_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable && have_work) begin
                    start   = 1'b1;
                    state_d = HIGH;
                    phase_d = HIGH_LOAD;
                end
            end
            HIGH: begin
                if (phase_q == '0) begin
                    state_d = LOW;
                    phase_d = LOW_LOAD;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            LOW: begin
                if (phase_q != '0) begin
                    phase_d = phase_q - 1'b1;
                end else if (QUEUE_EN && bus.enable && have_work) begin
                    start   = 1'b1;
                    state_d = HIGH;
                    phase_d = HIGH_LOAD;
                end else begin
                    state_d = IDLE;
                    phase_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q <= state_d;
            phase_q <= phase_d;
            pulse_q <= (state_d == HIGH);
        end
    end

`ifdef PULSE_GEN_QUEUE_EN
    logic [CNT_W-1:0] pending_q;

    assign have_work = bus.trigger || (pending_q != '0);
    assign drop      = bus.trigger && !start && (pending_q == CNT_W'(MAX_PENDING));

    // A trigger that coincides with a start replaces the queued event it would have consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else if (start && !bus.trigger) begin
            pending_q <= pending_q - 1'b1;
        end else if (!start && bus.trigger && !drop) begin
            pending_q <= pending_q + 1'b1;
        end
    end

    assign bus.pending = pending_q;
    assign bus.busy    = (state_q != IDLE) || (pending_q != '0);
`else
    assign have_work   = bus.trigger;
    assign drop        = bus.trigger && !start;
    assign bus.pending = '0;
    assign bus.busy    = (state_q != IDLE);
`endif

    // A new drop outranks a simultaneous clear so no lost trigger goes unreported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (bus.clr_overflow) begin
            overflow_q <= 1'b0;
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_min_width_pulse_gen.sv
// Scoreboard bench for min_width_pulse_gen: a timeline model predicts every cycle's outputs.
// Follows PULSE_GEN_QUEUE_EN the same way the design does.
module tb_min_width_pulse_gen;
    localparam int H     = 4;
    localparam int L     = 4;
    localparam int MAXP  = 7;
    localparam int CNT_W = 3;

    logic clk;
    logic rst_n;

    min_width_pulse_gen_if #(.CNT_W(CNT_W)) bus ();

    min_width_pulse_gen #(
        .HIGH_CYCLES(H),
        .LOW_CYCLES (L),
        .MAX_PENDING(MAXP),
        .CNT_W      (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             pulse;
        logic             busy;
        logic             ovf;
        logic [CNT_W-1:0] pend;
    } exp_t;

    exp_t exp_q[$];

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int m_start = -1000;
    int m_pend  = 0;
    bit m_ovf   = 1'b0;
    int hi_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: a pulse started at edge s is high after edges s..s+H-1 and low for the next L.
    task automatic step(input logic en, input logic trig, input logic clr);
        exp_t e;
        int   d;
        bit   can_start;
        bit   have;
        bit   start;
        bit   ovf_set;
        @(negedge clk);
        bus.enable       = en;
        bus.trigger      = trig;
        bus.clr_overflow = clr;
        d = cyc - m_start;
`ifdef PULSE_GEN_QUEUE_EN
        can_start = (d >= H + L);
        have      = trig || (m_pend != 0);
`else
        can_start = (d > H + L);
        have      = trig;
`endif
        start   = en && have && can_start;
        ovf_set = 1'b0;
        if (start) m_start = cyc;
`ifdef PULSE_GEN_QUEUE_EN
        if (start && !trig) begin
            m_pend--;
        end else if (!start && trig) begin
            if (m_pend == MAXP) ovf_set = 1'b1;
            else m_pend++;
        end
`else
        if (trig && !start) ovf_set = 1'b1;
`endif
        if (ovf_set) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        d      = cyc - m_start;
        e.pulse = (d < H);
        e.busy  = (d < H + L) || (m_pend != 0);
        e.ovf   = m_ovf;
        e.pend  = CNT_W'(m_pend);
        exp_q.push_back(e);
        cyc++;

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("pulse_out", 32'(bus.pulse_out), 32'(e.pulse));
        check("busy", 32'(bus.busy), 32'(e.busy));
        check("overflow", 32'(bus.overflow), 32'(e.ovf));
        check("pending", 32'(bus.pending), 32'(e.pend));
        if (bus.pulse_out === 1'b1) hi_cnt++;
    endtask

    task automatic reset_mid_cycle();
        @(negedge clk);
        bus.enable       = 1'b0;
        bus.trigger      = 1'b0;
        bus.clr_overflow = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_pulse", 32'(bus.pulse_out), 32'd0);
        check("rst_pending", 32'(bus.pending), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        m_start = cyc - 1000;
        m_pend  = 0;
        m_ovf   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n            = 1'b0;
        bus.enable       = 1'b0;
        bus.trigger      = 1'b0;
        bus.clr_overflow = 1'b0;
        repeat (3) @(negedge clk);
        check("init_pulse", 32'(bus.pulse_out), 32'd0);
        check("init_busy", 32'(bus.busy), 32'd0);
        check("init_pending", 32'(bus.pending), 32'd0);
        check("init_overflow", 32'(bus.overflow), 32'd0);
        rst_n = 1'b1;

        // Single trigger: exactly H high cycles, then idle after the low gap.
        repeat (10) step(1'b1, 1'b0, 1'b0);
        hi_cnt = 0;
        step(1'b1, 1'b1, 1'b0);
        repeat (12) step(1'b1, 1'b0, 1'b0);
        check("single_width", 32'(hi_cnt), 32'(H));

        // Three triggers on consecutive cycles.
        repeat (3) step(1'b1, 1'b1, 1'b0);
        repeat (30) step(1'b1, 1'b0, 1'b0);

        // Enable dropped during HIGH: pulse completes, queued work waits for enable.
        hi_cnt = 0;
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0, 1'b0);
        check("hold_width", 32'(hi_cnt), 32'(H));
`ifdef PULSE_GEN_QUEUE_EN
        check("hold_pending", 32'(bus.pending), 32'd2);
`else
        check("hold_pending", 32'(bus.pending), 32'd0);
`endif
        step(1'b1, 1'b0, 1'b0);
        repeat (30) step(1'b1, 1'b0, 1'b0);

        // Trigger burst saturates the queue, then the sticky flag and its clear.
        step(1'b0, 1'b0, 1'b1);
        repeat (12) step(1'b1, 1'b1, 1'b0);
`ifdef PULSE_GEN_QUEUE_EN
        check("burst_pending", 32'(bus.pending), 32'(MAXP));
`else
        check("burst_pending", 32'(bus.pending), 32'd0);
`endif
        check("burst_overflow", 32'(bus.overflow), 32'd1);
        step(1'b1, 1'b1, 1'b1);
        check("set_beats_clear", 32'(bus.overflow), 32'd1);
        step(1'b1, 1'b0, 1'b1);
        check("clear_overflow", 32'(bus.overflow), 32'd0);
        repeat (70) step(1'b1, 1'b0, 1'b0);

        // Reset on the second HIGH cycle with work queued.
        repeat (3) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("pre_reset_pulse", 32'(bus.pulse_out), 32'd1);
        reset_mid_cycle();
        hi_cnt = 0;
        repeat (20) step(1'b1, 1'b0, 1'b0);
        check("post_reset_quiet", 32'(hi_cnt), 32'd0);

        // Mixed random traffic.
        for (int i = 0; i < 300; i++) begin
            step(logic'($urandom_range(7) != 0), logic'($urandom_range(3) == 0),
                 logic'($urandom_range(15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
